// File: rtl/intc_service_master.sv
// Interrupt service master.
// Programs a priority table into an interrupt controller over an APB-style
// bus (write then read-back per peripheral) and services interrupts one at
// a time: capture the ID, stay busy for a fixed time, acknowledge, then wait
// for the controller to drop its request before accepting another.
//
// Handshake: an APB transfer has a one-cycle setup phase (penable=0) and an
// access phase (penable=1). In the access phase every APB output is held
// until pready=1 is sampled on a rising edge, which completes the transfer.
// There is no timeout. interrupt_valid is a level request. interrupt_serviced
// pulses for one cycle per serviced interrupt, and the block then waits for
// interrupt_valid=0 before it can accept a new interrupt.
module intc_service_master #(
    parameter int NO_OF_PERIPHERALS = 8,
    parameter int WIDTH             = $clog2(NO_OF_PERIPHERALS),
    parameter int SERVICE_CYCLES    = 4
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           cfg_start,
    input  logic [NO_OF_PERIPHERALS*WIDTH-1:0] cfg_prio,
    output logic                           cfg_done,
    output logic                           cfg_error,
    output logic [WIDTH-1:0]               paddr,
    output logic [WIDTH-1:0]               pwdata,
    output logic                           pwrite,
    output logic                           penable,
    input  logic [WIDTH-1:0]               prdata,
    input  logic                           pready,
    input  logic                           interrupt_valid,
    input  logic [WIDTH-1:0]               interrupt_to_be_service,
    output logic                           interrupt_serviced,
    output logic                           isr_busy,
    output logic [WIDTH-1:0]               isr_id,
    output logic [15:0]                    service_count
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CFG_SETUP  = 3'd1;
    localparam logic [2:0] CFG_ACCESS = 3'd2;
    localparam logic [2:0] SERVICE    = 3'd3;
    localparam logic [2:0] ACK        = 3'd4;
    localparam logic [2:0] ACK_WAIT   = 3'd5;

    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(NO_OF_PERIPHERALS - 1);
    localparam logic [7:0]       SVC_LAST = 8'(SERVICE_CYCLES - 1);

    logic [2:0]       state;
    logic             pending;
    logic [WIDTH-1:0] idx;
    logic             rd_phase;
    logic [7:0]       svc_cnt;
    logic [WIDTH-1:0] prio_q [NO_OF_PERIPHERALS];
    logic [WIDTH-1:0] idx_next;
    logic             start_run;

    // An interrupt in IDLE always wins over a programming request.
    assign start_run = (state == IDLE) && !interrupt_valid && (cfg_start || pending);
    assign idx_next  = idx + WIDTH'(1);

    // Snapshot of the priority table, taken when a programming run starts.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            for (int i = 0; i < NO_OF_PERIPHERALS; i++) begin
                prio_q[i] <= '0;
            end
        end else if (start_run) begin
            for (int i = 0; i < NO_OF_PERIPHERALS; i++) begin
                prio_q[i] <= cfg_prio[i*WIDTH +: WIDTH];
            end
        end
    end

    // Main controller: programming sequence, interrupt service and all outputs.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state              <= IDLE;
            pending            <= 1'b0;
            idx                <= '0;
            rd_phase           <= 1'b0;
            svc_cnt            <= 8'd0;
            paddr              <= '0;
            pwdata             <= '0;
            pwrite             <= 1'b0;
            penable            <= 1'b0;
            cfg_done           <= 1'b0;
            cfg_error          <= 1'b0;
            interrupt_serviced <= 1'b0;
            isr_busy           <= 1'b0;
            isr_id             <= '0;
            service_count      <= 16'd0;
        end else begin
            cfg_done           <= 1'b0;
            interrupt_serviced <= 1'b0;
            // Requests arriving while busy merge into a single pending run.
            if (cfg_start) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (interrupt_valid) begin
                        isr_id   <= interrupt_to_be_service;
                        isr_busy <= 1'b1;
                        svc_cnt  <= 8'd0;
                        state    <= SERVICE;
                    end else if (cfg_start || pending) begin
                        pending   <= 1'b0;
                        cfg_error <= 1'b0;
                        idx       <= '0;
                        rd_phase  <= 1'b0;
                        paddr     <= '0;
                        pwdata    <= cfg_prio[WIDTH-1:0];
                        pwrite    <= 1'b1;
                        penable   <= 1'b0;
                        state     <= CFG_SETUP;
                    end
                end
                CFG_SETUP: begin
                    penable <= 1'b1;
                    state   <= CFG_ACCESS;
                end
                CFG_ACCESS: begin
                    if (pready) begin
                        penable <= 1'b0;
                        if (rd_phase) begin
                            if (prdata != prio_q[idx]) begin
                                cfg_error <= 1'b1;
                            end
                            if (idx == LAST_IDX) begin
                                cfg_done <= 1'b1;
                                pwrite   <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                idx      <= idx_next;
                                rd_phase <= 1'b0;
                                paddr    <= idx_next;
                                pwdata   <= prio_q[idx_next];
                                pwrite   <= 1'b1;
                                state    <= CFG_SETUP;
                            end
                        end else begin
                            // Read back the same address just written.
                            rd_phase <= 1'b1;
                            pwrite   <= 1'b0;
                            state    <= CFG_SETUP;
                        end
                    end
                end
                SERVICE: begin
                    if (svc_cnt == SVC_LAST) begin
                        state <= ACK;
                    end else begin
                        svc_cnt <= svc_cnt + 8'd1;
                    end
                end
                ACK: begin
                    interrupt_serviced <= 1'b1;
                    if (service_count != 16'hFFFF) begin
                        service_count <= service_count + 16'd1;
                    end
                    state <= ACK_WAIT;
                end
                ACK_WAIT: begin
                    // A still-asserted request is the one just serviced.
                    if (!interrupt_valid) begin
                        isr_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
